// File: rtl/datapath_sequencer.sv
// datapath_sequencer: Moore control FSM for the simple-RISC datapath.
// Sequences MOV-imm, MOV-reg, ADD/CMP/AND/MVN, LDR/STR over a ready-handshaked
// memory port with a bounded wait counter, plus HALT and an error state.
// opcode/op are held stable by the issuer from s until w returns high, so the
// instruction class is decoded directly from them in every state.
module datapath_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ENABLE_MEM  = 1,
    parameter int unsigned ERR_STICKY  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_ready,
    output logic       w,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic       err
);

    localparam int unsigned CW     = $clog2(MEM_TIMEOUT + 1);
    localparam bit          MEM_EN = (ENABLE_MEM != 0);
    localparam bit          STICKY = (ERR_STICKY != 0);

    typedef enum logic [4:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_COMP,
        S_WRITE_REG, S_ADDR_CALC, S_LOAD_ADDR, S_MEM_RD, S_WRITE_MEM,
        S_GET_D, S_PASS_D, S_MEM_WR, S_HALT, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic is_movi, is_movr, is_add, is_cmp, is_and, is_mvn;
    logic is_ldr, is_str, is_halt, mem_timeout;

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_add  = (opcode == 3'b101) && (op == 2'b00);
    assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
    assign is_and  = (opcode == 3'b101) && (op == 2'b10);
    assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);
    assign is_halt = (opcode == 3'b111);

    // Last allowed ready-low cycle of a memory state.
    assign mem_timeout = (cnt_q == CW'(MEM_TIMEOUT - 1));

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state routing; counter is zero outside memory states so entry clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_WAIT:      if (s) state_d = S_DECODE;
            S_DECODE: begin
                if (is_movi)                            state_d = S_WRITE_IMM;
                else if (is_movr || is_mvn)             state_d = S_GET_B;
                else if (is_add || is_cmp || is_and)    state_d = S_GET_A;
                else if ((is_ldr || is_str) && MEM_EN)  state_d = S_GET_A;
                else if (is_halt)                       state_d = S_HALT;
                else                                    state_d = S_ERR;
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = (is_ldr || is_str) ? S_ADDR_CALC : S_GET_B;
            S_GET_B:     state_d = is_cmp ? S_COMP : S_ALU;
            S_ALU:       state_d = S_WRITE_REG;
            S_COMP:      state_d = S_WAIT;
            S_WRITE_REG: state_d = S_WAIT;
            S_ADDR_CALC: state_d = S_LOAD_ADDR;
            S_LOAD_ADDR: state_d = is_ldr ? S_MEM_RD : S_GET_D;
            S_MEM_RD: begin
                if (mem_ready)        state_d = S_WRITE_MEM;
                else if (mem_timeout) state_d = S_ERR;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            S_WRITE_MEM: state_d = S_WAIT;
            S_GET_D:     state_d = S_PASS_D;
            S_PASS_D:    state_d = S_MEM_WR;
            S_MEM_WR: begin
                if (mem_ready)        state_d = S_WAIT;
                else if (mem_timeout) state_d = S_ERR;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            S_HALT:      state_d = S_HALT;
            S_ERR:       if (!STICKY) state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Moore outputs decoded from the current state only.
    always_comb begin
        w         = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        nsel      = 3'b000;
        vsel      = 2'b00;
        write     = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = 2'b00;
        halted    = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_WAIT:      w = 1'b1;
            S_WRITE_IMM: begin nsel = 3'b001; vsel = 2'b10; write = 1'b1; end
            S_GET_A:     begin nsel = 3'b001; loada = 1'b1; end
            S_GET_B:     begin nsel = 3'b010; loadb = 1'b1; end
            S_ALU:       begin loadc = 1'b1; asel = is_movr || is_mvn; end
            S_COMP:      loads = 1'b1;
            S_WRITE_REG: begin nsel = 3'b100; vsel = 2'b00; write = 1'b1; end
            S_ADDR_CALC: begin bsel = 1'b1; loadc = 1'b1; end
            S_LOAD_ADDR: load_addr = 1'b1;
            S_MEM_RD:    mem_cmd = 2'b01;
            S_WRITE_MEM: begin nsel = 3'b100; vsel = 2'b11; write = 1'b1; end
            S_GET_D:     begin nsel = 3'b100; loadb = 1'b1; end
            S_PASS_D:    begin asel = 1'b1; loadc = 1'b1; end
            S_MEM_WR:    mem_cmd = 2'b10;
            S_HALT:      halted = 1'b1;
            S_ERR:       err = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: three instances share one stimulus stream
// (TIMEOUT=4 sticky, TIMEOUT=4 non-sticky, memory disabled); per-instruction
// observations are compared against a latency/activity model of each class.
module tb_datapath_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       mem_ready = 1'b0;

    logic       w_a[3], loada_a[3], loadb_a[3], loadc_a[3], loads_a[3];
    logic       asel_a[3], bsel_a[3], write_a[3], load_addr_a[3];
    logic       halted_a[3], err_a[3];
    logic [2:0] nsel_a[3];
    logic [1:0] vsel_a[3], mem_cmd_a[3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    datapath_sequencer #(.MEM_TIMEOUT(4), .ENABLE_MEM(1), .ERR_STICKY(1)) u_dut0 (
        .clk(clk), .rst(rst), .s(s), .opcode(opcode), .op(op), .mem_ready(mem_ready),
        .w(w_a[0]), .loada(loada_a[0]), .loadb(loadb_a[0]), .loadc(loadc_a[0]),
        .loads(loads_a[0]), .asel(asel_a[0]), .bsel(bsel_a[0]), .nsel(nsel_a[0]),
        .vsel(vsel_a[0]), .write(write_a[0]), .load_addr(load_addr_a[0]),
        .mem_cmd(mem_cmd_a[0]), .halted(halted_a[0]), .err(err_a[0]));

    datapath_sequencer #(.MEM_TIMEOUT(4), .ENABLE_MEM(1), .ERR_STICKY(0)) u_dut1 (
        .clk(clk), .rst(rst), .s(s), .opcode(opcode), .op(op), .mem_ready(mem_ready),
        .w(w_a[1]), .loada(loada_a[1]), .loadb(loadb_a[1]), .loadc(loadc_a[1]),
        .loads(loads_a[1]), .asel(asel_a[1]), .bsel(bsel_a[1]), .nsel(nsel_a[1]),
        .vsel(vsel_a[1]), .write(write_a[1]), .load_addr(load_addr_a[1]),
        .mem_cmd(mem_cmd_a[1]), .halted(halted_a[1]), .err(err_a[1]));

    datapath_sequencer #(.MEM_TIMEOUT(15), .ENABLE_MEM(0), .ERR_STICKY(1)) u_dut2 (
        .clk(clk), .rst(rst), .s(s), .opcode(opcode), .op(op), .mem_ready(mem_ready),
        .w(w_a[2]), .loada(loada_a[2]), .loadb(loadb_a[2]), .loadc(loadc_a[2]),
        .loads(loads_a[2]), .asel(asel_a[2]), .bsel(bsel_a[2]), .nsel(nsel_a[2]),
        .vsel(vsel_a[2]), .write(write_a[2]), .load_addr(load_addr_a[2]),
        .mem_cmd(mem_cmd_a[2]), .halted(halted_a[2]), .err(err_a[2]));

    // Summary of one instruction: edges until w/err/halted (counting the s edge),
    // pulse counts of each strobe, memory-command cycles and the write target.
    typedef struct packed {
        logic [7:0] n;
        logic [3:0] loada, loadb, loadc, loads, load_addr, asel, bsel, writes;
        logic [7:0] memcyc;
        logic [1:0] mcmd;
        logic [2:0] wr_nsel;
        logic [1:0] wr_vsel;
        logic       err;
        logic       halted;
    } obs_t;

    function automatic logic [17:0] outs(input int idx);
        return {w_a[idx], loada_a[idx], loadb_a[idx], loadc_a[idx], loads_a[idx],
                asel_a[idx], bsel_a[idx], nsel_a[idx], vsel_a[idx], write_a[idx],
                load_addr_a[idx], mem_cmd_a[idx], halted_a[idx], err_a[idx]};
    endfunction

    // Expected behaviour per instruction class; k = ready-low cycles before ready.
    function automatic obs_t model(input int idx, input logic [2:0] opc,
                                   input logic [1:0] opv, input int k);
        int   t  = (idx == 2) ? 15 : 4;
        bit   en = (idx != 2);
        obs_t e  = '0;
        if (opc == 3'b111) begin
            e.n = 8'd2; e.halted = 1'b1;
        end else if (opc == 3'b110 && opv == 2'b10) begin
            e.n = 8'd3; e.writes = 4'd1; e.wr_nsel = 3'b001; e.wr_vsel = 2'b10;
        end else if ((opc == 3'b110 && opv == 2'b00) || (opc == 3'b101 && opv == 2'b11)) begin
            e.n = 8'd5; e.loadb = 4'd1; e.loadc = 4'd1; e.asel = 4'd1;
            e.writes = 4'd1; e.wr_nsel = 3'b100; e.wr_vsel = 2'b00;
        end else if (opc == 3'b101 && opv == 2'b01) begin
            e.n = 8'd5; e.loada = 4'd1; e.loadb = 4'd1; e.loads = 4'd1;
        end else if (opc == 3'b101) begin
            e.n = 8'd6; e.loada = 4'd1; e.loadb = 4'd1; e.loadc = 4'd1;
            e.writes = 4'd1; e.wr_nsel = 3'b100; e.wr_vsel = 2'b00;
        end else if (en && opc == 3'b011 && opv == 2'b00) begin
            e.loada = 4'd1; e.bsel = 4'd1; e.loadc = 4'd1; e.load_addr = 4'd1; e.mcmd = 2'b01;
            if (k < t) begin
                e.n = 8'(7 + k); e.memcyc = 8'(k + 1);
                e.writes = 4'd1; e.wr_nsel = 3'b100; e.wr_vsel = 2'b11;
            end else begin
                e.n = 8'(5 + t); e.memcyc = 8'(t); e.err = 1'b1;
            end
        end else if (en && opc == 3'b100 && opv == 2'b00) begin
            e.loada = 4'd1; e.bsel = 4'd1; e.loadc = 4'd2; e.load_addr = 4'd1;
            e.loadb = 4'd1; e.asel = 4'd1; e.mcmd = 2'b10;
            if (k < t) begin
                e.n = 8'(8 + k); e.memcyc = 8'(k + 1);
            end else begin
                e.n = 8'(7 + t); e.memcyc = 8'(t); e.err = 1'b1;
            end
        end else begin
            e.n = 8'd2; e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one instruction and observe instance idx until w, err or halted.
    task automatic run_instr(input int idx, input logic [2:0] opc, input logic [1:0] opv,
                             input int k, output obs_t o);
        int  edges = 0;
        bit  done  = 1'b0;
        o = '0;
        @(negedge clk);
        opcode = opc; op = opv; s = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            s = 1'b0;
            if (w_a[idx]) begin done = 1'b1; break; end
            o.loada     = o.loada     + 4'(loada_a[idx]);
            o.loadb     = o.loadb     + 4'(loadb_a[idx]);
            o.loadc     = o.loadc     + 4'(loadc_a[idx]);
            o.loads     = o.loads     + 4'(loads_a[idx]);
            o.load_addr = o.load_addr + 4'(load_addr_a[idx]);
            o.asel      = o.asel      + 4'(asel_a[idx]);
            o.bsel      = o.bsel      + 4'(bsel_a[idx]);
            if (write_a[idx]) begin
                o.writes  = o.writes + 4'd1;
                o.wr_nsel = nsel_a[idx];
                o.wr_vsel = vsel_a[idx];
            end
            if (mem_cmd_a[idx] != 2'b00) begin
                o.memcyc = o.memcyc + 8'd1;
                o.mcmd   = o.mcmd | mem_cmd_a[idx];
            end
            mem_ready = (mem_cmd_a[idx] != 2'b00) && (int'(o.memcyc) > k);
            if (err_a[idx] || halted_a[idx]) begin
                o.err = err_a[idx]; o.halted = halted_a[idx];
                done = 1'b1;
                break;
            end
        end
        mem_ready = 1'b0;
        o.n = done ? 8'(edges) : 8'hFF;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; s = 1'b1; opcode = 3'b110; op = 2'b10;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; s = 1'b0;
        n_checks++;
        if (outs(0) !== 18'h20000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", outs(0), 18'h20000);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (w_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold_wait: w got %b expected 1", w_a[0]);
        end
    endtask

    task automatic test_mov_imm();
        obs_t o;
        obs_t e;
        run_instr(0, 3'b110, 2'b10, 0, o);
        e = model(0, 3'b110, 2'b10, 0);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL mov_imm: got %h expected %h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        obs_t e;
        run_instr(0, 3'b101, 2'b00, 0, o);
        e = model(0, 3'b101, 2'b00, 0);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL add: got %h expected %h", o, e);
        end
        run_instr(0, 3'b101, 2'b01, 0, o);
        e = model(0, 3'b101, 2'b01, 0);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL cmp: got %h expected %h", o, e);
        end
    endtask

    task automatic test_ldr();
        obs_t o;
        obs_t e;
        run_instr(0, 3'b011, 2'b00, 3, o);
        e = model(0, 3'b011, 2'b00, 3);
        n_checks++;
        if (o !== e || o.n !== 8'd10 || o.memcyc !== 8'd4) begin
            n_fail++;
            $display("FAIL ldr_wait3: got %h expected %h", o, e);
        end
        run_instr(0, 3'b011, 2'b00, 3, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL ldr_repeat_counter_clear: got %h expected %h", o, e);
        end
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk);
        opcode = 3'b011; op = 2'b00; s = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            s = 1'b0;
        end
        n_checks++;
        if (mem_cmd_a[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_mem_read_active: mem_cmd got %b expected 01", mem_cmd_a[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (outs(0) !== 18'h20000) begin
            n_fail++;
            $display("FAIL mid_mem_reset: got %h expected %h", outs(0), 18'h20000);
        end
    endtask

    task automatic test_sticky_err();
        obs_t o;
        obs_t e;
        do_reset();
        run_instr(0, 3'b100, 2'b00, 255, o);
        e = model(0, 3'b100, 2'b00, 255);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL str_timeout: got %h expected %h", o, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({err_a[0], w_a[0], mem_cmd_a[0]} !== 4'b1000) begin
                n_fail++;
                $display("FAIL err_sticky: got %b expected 1000",
                         {err_a[0], w_a[0], mem_cmd_a[0]});
            end
        end
        do_reset();
        n_checks++;
        if (outs(0) !== 18'h20000) begin
            n_fail++;
            $display("FAIL err_reset_clear: got %h expected %h", outs(0), 18'h20000);
        end
    endtask

    task automatic test_nonsticky();
        obs_t o;
        obs_t e;
        do_reset();
        run_instr(1, 3'b100, 2'b00, 255, o);
        e = model(1, 3'b100, 2'b00, 255);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL ns_str_timeout: got %h expected %h", o, e);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({err_a[1], w_a[1]} !== 2'b01) begin
            n_fail++;
            $display("FAIL ns_err_release: err,w got %b expected 01", {err_a[1], w_a[1]});
        end
        run_instr(1, 3'b000, 2'b00, 0, o);
        e = model(1, 3'b000, 2'b00, 0);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL illegal_opcode: got %h expected %h", o, e);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({err_a[1], w_a[1]} !== 2'b01) begin
            n_fail++;
            $display("FAIL ns_illegal_release: err,w got %b expected 01", {err_a[1], w_a[1]});
        end
        do_reset();
    endtask

    task automatic test_halt();
        obs_t o;
        obs_t e;
        run_instr(0, 3'b111, 2'b00, 0, o);
        e = model(0, 3'b111, 2'b00, 0);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL halt_entry: got %h expected %h", o, e);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s = i[0]; opcode = 3'b110; op = 2'b10;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({halted_a[0], w_a[0], write_a[0]} !== 3'b100) begin
                n_fail++;
                $display("FAIL halt_hold: halted,w,write got %b expected 100",
                         {halted_a[0], w_a[0], write_a[0]});
            end
        end
        s = 1'b0;
        do_reset();
    endtask

    task automatic test_no_mem();
        obs_t o;
        obs_t e;
        logic [4:0] seq[3];
        seq = '{5'b011_00, 5'b100_00, 5'b101_00};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            run_instr(2, seq[i][4:2], seq[i][1:0], 0, o);
            e = model(2, seq[i][4:2], seq[i][1:0], 0);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL no_mem op=%b: got %h expected %h", seq[i], o, e);
            end
        end
        do_reset();
    endtask

    task automatic test_random();
        obs_t o;
        obs_t e;
        logic [4:0] tbl[10];
        logic [4:0] ins;
        int k;
        tbl = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10,
                5'b101_11, 5'b011_00, 5'b100_00, 5'b011_00, 5'b100_00};
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 11) < 10) ins = tbl[$urandom_range(0, 9)];
            else                            ins = 5'($urandom_range(0, 31));
            k = int'($urandom_range(0, 5));
            run_instr(0, ins[4:2], ins[1:0], k, o);
            e = model(0, ins[4:2], ins[1:0], k);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random[%0d] op=%b k=%0d: got %h expected %h", i, ins, k, o, e);
            end
            if (o.err || o.halted || o.n == 8'hFF) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_back_to_back();
        test_ldr();
        test_reset_mid_mem();
        test_sticky_err();
        test_nonsticky();
        test_halt();
        test_no_mem();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Parametrised control FSM for the simple-RISC datapath, successor to the single-cycle-decode register/ALU controller. Sequences MOV-immediate, MOV-register, the four ALU ops (ADD, CMP, AND, MVN), and the LDR/STR memory instructions over a ready-handshaked memory port with a bounded wait counter, plus HALT and an error state. Sits between the instruction register (opcode/op) and the datapath/memory control pins; all outputs are Moore outputs of the current state.

## Interface
- MEM_TIMEOUT, 15: max cycles a memory state waits for `mem_ready` before error; legal range 1..255.
- ENABLE_MEM, 1: 1 = LDR/STR decoded; 0 = LDR/STR treated as illegal.
- ERR_STICKY, 1: 1 = ERR holds until `rst`; 0 = ERR lasts one cycle, then WAIT.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; one clock, synchronous, active-high.
- s  in  1  start; sampled only in WAIT.
- opcode  in  3  instruction class; held stable from `s` until `w` returns high.
- op  in  2  sub-op; same stability rule.
- mem_ready  in  1  memory completion handshake.
- w  out  1  idle/ready (high only in WAIT).
- loada, loadb, loadc, loads  out  1 each  datapath register loads.
- asel, bsel  out  1 each  asel=1 forces ALU A input to 0; bsel=1 selects sign-extended imm5 for B.
- nsel  out  3  one-hot register select {Rd,Rm,Rn}; 000 when unused.
- vsel  out  2  write-back source: 00 C, 01 PC, 10 IMM, 11 MDATA.
- write  out  1  register-file write enable.
- load_addr  out  1  loads memory address register from C.
- mem_cmd  out  2  00 none, 01 read, 10 write.
- halted  out  1  high in HALT.
- err  out  1  high in ERR.

## Operation
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, COMP, WRITE_REG, ADDR_CALC, LOAD_ADDR, MEM_RD, WRITE_MEM, GET_D, PASS_D, MEM_WR, HALT, ERR.
- Default outputs 0 / 00 / 000 in every state unless listed.
- WAIT: w=1; s=1 → DECODE.
- DECODE routing (opcode/op): 110/10 → WRITE_IMM; 110/00 and 101/11 → GET_B; 101/00, 101/01, 101/10 → GET_A; 011/00 and 100/00 → GET_A if ENABLE_MEM else ERR; 111/xx → HALT; anything else → ERR.
- WRITE_IMM: nsel=001, vsel=10, write=1 → WAIT.
- GET_A: nsel=001, loada=1 → ALU-class: GET_B; LDR/STR: ADDR_CALC.
- GET_B: nsel=010, loadb=1 → CMP: COMP; else ALU.
- ALU: loadc=1; asel=1 for MOV-reg and MVN → WRITE_REG.
- COMP: loads=1 → WAIT (no register write).
- WRITE_REG: nsel=100, vsel=00, write=1 → WAIT.
- ADDR_CALC: bsel=1, loadc=1 → LOAD_ADDR.
- LOAD_ADDR: load_addr=1 → LDR: MEM_RD; STR: GET_D.
- MEM_RD: mem_cmd=01 → WRITE_MEM on mem_ready.
- WRITE_MEM: nsel=100, vsel=11, write=1 → WAIT.
- GET_D: nsel=100, loadb=1 → PASS_D.
- PASS_D: asel=1, loadc=1 → MEM_WR.
- MEM_WR: mem_cmd=10 → WAIT on mem_ready.
- Wait counter (width clog2(MEM_TIMEOUT+1)): cleared on entry to MEM_RD/MEM_WR; each cycle there with mem_ready=0: if count == MEM_TIMEOUT-1 → ERR, else count+1. mem_ready=1 always wins over timeout in the same cycle.
- HALT: halted=1; exits only on rst; s ignored.
- ERR: err=1; ERR_STICKY=1 holds until rst, else → WAIT next cycle.

## Timing
- Reset: next posedge state=WAIT, counter=0; outputs then w=1, all others 0. Reset mid-operation (including mid-memory wait) aborts immediately; no write/mem_cmd after the reset edge. rst dominates s.
- Latency, s sampled at edge 0, w high again after edge N: MOV-imm N=3; CMP N=5; MOV-reg/MVN N=5; ADD/AND N=6; LDR N=7+k; STR N=8+k, where k = number of mem_ready-low cycles (k < MEM_TIMEOUT).
- mem_cmd stays asserted and stable every cycle of MEM_RD/MEM_WR until mem_ready sampled high; deasserts after that edge.
- Timeout: mem_ready low for MEM_TIMEOUT consecutive cycles → ERR entered on that edge, err=1 next cycle.
- write is high for exactly one cycle per instruction (none for CMP, STR, HALT, ERR).

## Test plan
- Reset: rst=1 with s=1 for one edge → w=1, err=0, halted=0, mem_cmd=00, write=0.
- MOV R?,#imm (110/10), s pulse → WRITE_IMM cycle shows nsel=001, vsel=10, write=1; w high 3 cycles after s.
- ADD (101/00) then CMP (101/01) back to back → ADD: loada, loadb, loadc, write each one cycle, w after 6; CMP: loads=1 one cycle, write never high, w after 5.
- LDR (011/00), mem_ready low 3 cycles then high → mem_cmd=01 for 4 cycles, then vsel=11/nsel=100/write=1; w after 10 cycles.
- STR (100/00), MEM_TIMEOUT=4, mem_ready held low → mem_cmd=10 for 4 cycles, then err=1 sticky; rst clears to WAIT. Repeat with ERR_STICKY=0 → WAIT one cycle after err.
- HALT (111/00) → halted=1, s pulses ignored for 20 cycles; opcode 000 → err=1; ENABLE_MEM=0 with LDR → err=1 after DECODE.
